// File: rtl/bus_req_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_req_arbiter_if
// Brief    : Fetch, data and downstream bus signals of the request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int c_strb_width = DATA_WIDTH / 8;

    logic                    i_valid;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [2:0]              i_size;
    logic                    i_addr_ok;
    logic                    i_data_ok;
    logic [DATA_WIDTH-1:0]   i_data;

    logic                    d_valid;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [2:0]              d_size;
    logic [c_strb_width-1:0] d_strobe;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic                    d_addr_ok;
    logic                    d_data_ok;
    logic [DATA_WIDTH-1:0]   d_data;

    logic                    m_valid;
    logic                    m_write;
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [2:0]              m_size;
    logic [c_strb_width-1:0] m_strobe;
    logic [DATA_WIDTH-1:0]   m_wdata;
    logic                    m_addr_ok;
    logic                    m_data_ok;
    logic [DATA_WIDTH-1:0]   m_rdata;

    // Arbiter view: requester inputs and downstream responses come in
    modport slave (
        input  i_valid, i_addr, i_size,
        output i_addr_ok, i_data_ok, i_data,
        input  d_valid, d_addr, d_size, d_strobe, d_wdata,
        output d_addr_ok, d_data_ok, d_data,
        output m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport master (
        output i_valid, i_addr, i_size,
        input  i_addr_ok, i_data_ok, i_data,
        output d_valid, d_addr, d_size, d_strobe, d_wdata,
        input  d_addr_ok, d_data_ok, d_data,
        input  m_valid, m_write, m_addr, m_size, m_strobe, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bus_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bus_req_arbiter
// Brief    : Round-robin arbiter sharing one split-transaction bus between
//            instruction fetch (I) and data access (D), one transaction at once.
// Revision : 1.0 - initial release
// ============================================================================
module bus_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input wire               clk,
    input wire               reset,
    bus_req_arbiter_if.slave bus
);
    localparam int c_strb_width = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    // With one transaction in flight the current grant is also the last grant
    logic                    r_last_d;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [2:0]              r_m_size;
    logic [c_strb_width-1:0] r_m_strobe;
    logic [DATA_WIDTH-1:0]   r_m_wdata;

    logic                    w_load;
    logic                    w_pick_d;
    logic                    w_addr_ack;
    logic                    w_data_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_d   <= 1'b1;
            r_m_addr   <= '0;
            r_m_size   <= '0;
            r_m_strobe <= '0;
            r_m_wdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_last_d   <= w_pick_d;
                r_m_addr   <= w_pick_d ? bus.d_addr   : bus.i_addr;
                r_m_size   <= w_pick_d ? bus.d_size   : bus.i_size;
                r_m_strobe <= w_pick_d ? bus.d_strobe : '0;
                r_m_wdata  <= w_pick_d ? bus.d_wdata  : '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_addr_ack   = 1'b0;
        w_data_ack   = 1'b0;
        // D wins when alone, or on contention when I was served last
        w_pick_d     = bus.d_valid & (~bus.i_valid | ~r_last_d);
        case (r_state)
            S_IDLE: begin
                if (bus.i_valid | bus.d_valid) begin
                    w_load       = 1'b1;
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.m_addr_ok) begin
                    w_addr_ack   = 1'b1;
                    w_data_ack   = bus.m_data_ok;
                    w_state_next = bus.m_data_ok ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bus.m_data_ok) begin
                    w_data_ack   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.m_valid   = (r_state == S_ADDR);
    assign bus.m_write   = |r_m_strobe;
    assign bus.m_addr    = r_m_addr;
    assign bus.m_size    = r_m_size;
    assign bus.m_strobe  = r_m_strobe;
    assign bus.m_wdata   = r_m_wdata;

    assign bus.i_addr_ok = w_addr_ack & ~r_last_d;
    assign bus.i_data_ok = w_data_ack & ~r_last_d;
    assign bus.d_addr_ok = w_addr_ack &  r_last_d;
    assign bus.d_data_ok = w_data_ack &  r_last_d;
    assign bus.i_data    = bus.m_rdata;
    assign bus.d_data    = bus.m_rdata;
endmodule
`default_nettype wire

// File: tb/tb_bus_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bus_req_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            transaction-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_req_arbiter;
    localparam int c_aw = 32;
    localparam int c_dw = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    bus_req_arbiter_if #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) bus ();

    bus_req_arbiter #(.ADDR_WIDTH(c_aw), .DATA_WIDTH(c_dw)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.i_valid   = 1'b0; bus.i_addr  = '0; bus.i_size = '0;
        bus.d_valid   = 1'b0; bus.d_addr  = '0; bus.d_size = '0;
        bus.d_strobe  = '0;   bus.d_wdata = '0;
        bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = '0;
    endtask

    // Inputs are driven 1 time unit after a rising edge, outputs sampled 1 later
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({bus.m_valid, bus.m_write, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {bus.m_valid, bus.m_write, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        n_checks++;
        if ({bus.m_addr, bus.m_size, bus.m_strobe, bus.m_wdata} !== '0) begin
            n_errors++;
            $display("FAIL reset_fields: got addr=%h size=%h strobe=%h wdata=%h expected all 0", bus.m_addr, bus.m_size, bus.m_strobe, bus.m_wdata);
        end
    endtask

    task automatic test_single_fetch();
        do_reset();
        bus.i_valid = 1'b1; bus.i_addr = 32'hBFC0_0000; bus.i_size = 3'd2;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL fetch_c0_mvalid: got %b expected 0", bus.m_valid); end
        next_cycle(); #1;
        n_checks++;
        if ({bus.m_valid, bus.m_write, bus.m_addr, bus.m_size} !== {1'b1, 1'b0, 32'hBFC0_0000, 3'd2}) begin
            n_errors++;
            $display("FAIL fetch_c1_req: got v=%b w=%b a=%h s=%h expected v=1 w=0 a=bfc00000 s=2", bus.m_valid, bus.m_write, bus.m_addr, bus.m_size);
        end
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b0000) begin
            n_errors++; $display("FAIL fetch_c1_oks: got %b expected 0000", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); bus.m_addr_ok = 1'b1; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b1000) begin
            n_errors++; $display("FAIL fetch_c2_oks: got %b expected 1000", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); bus.m_addr_ok = 1'b0; bus.i_valid = 1'b0; #1;
        n_checks++;
        if ({bus.m_valid, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 5'b0) begin
            n_errors++; $display("FAIL fetch_c3: got %b expected 00000", {bus.m_valid, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); bus.m_data_ok = 1'b1; bus.m_rdata = 32'h2408_0001; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b0100) begin
            n_errors++; $display("FAIL fetch_c4_oks: got %b expected 0100", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        n_checks++;
        if (bus.i_data !== 32'h2408_0001) begin n_errors++; $display("FAIL fetch_c4_data: got %h expected 24080001", bus.i_data); end
        next_cycle(); bus.m_data_ok = 1'b0; #1;
        n_checks++;
        if ({bus.m_valid, bus.i_data_ok, bus.d_data_ok} !== 3'b0) begin
            n_errors++; $display("FAIL fetch_c5: got %b expected 000", {bus.m_valid, bus.i_data_ok, bus.d_data_ok});
        end
    endtask

    task automatic test_alternation();
        logic exp_d;
        do_reset();
        bus.i_valid = 1'b1; bus.i_addr = 32'h0000_1000; bus.i_size = 3'd2;
        bus.d_valid = 1'b1; bus.d_addr = 32'h0000_2000; bus.d_size = 3'd2;
        bus.d_strobe = 4'hF; bus.d_wdata = 32'hDEAD_BEEF;
        #1;
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2 == 1);
            n_checks++;
            if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL alt_idle[%0d]: got m_valid=%b expected 0", t, bus.m_valid); end
            next_cycle(); bus.m_addr_ok = 1'b1; #1;
            n_checks++;
            if ({bus.m_valid, bus.m_write, bus.m_addr, bus.m_strobe} !==
                {1'b1, exp_d, (exp_d ? 32'h0000_2000 : 32'h0000_1000), (exp_d ? 4'hF : 4'h0)}) begin
                n_errors++;
                $display("FAIL alt_req[%0d]: got v=%b w=%b a=%h st=%h expected owner_d=%b", t, bus.m_valid, bus.m_write, bus.m_addr, bus.m_strobe, exp_d);
            end
            if (exp_d) begin
                n_checks++;
                if (bus.m_wdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL alt_wdata[%0d]: got %h expected deadbeef", t, bus.m_wdata); end
            end
            n_checks++;
            if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== (exp_d ? 4'b0010 : 4'b1000)) begin
                n_errors++; $display("FAIL alt_aok[%0d]: got %b expected owner_d=%b", t, {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok}, exp_d);
            end
            next_cycle(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b1; bus.m_rdata = 32'(t + 100); #1;
            n_checks++;
            if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== (exp_d ? 4'b0001 : 4'b0100)) begin
                n_errors++; $display("FAIL alt_dok[%0d]: got %b expected owner_d=%b", t, {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok}, exp_d);
            end
            next_cycle(); bus.m_data_ok = 1'b0; #1;
        end
    endtask

    task automatic test_combined_ok();
        do_reset();
        bus.i_valid = 1'b1; bus.i_addr = 32'h0000_0040;
        bus.d_valid = 1'b1; bus.d_addr = 32'h0000_0080; bus.d_strobe = 4'h0;
        next_cycle(); bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; #1;
        n_checks++;
        if ({bus.m_valid, bus.m_addr, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== {1'b1, 32'h40, 4'b1100}) begin
            n_errors++; $display("FAIL comb_ok: got v=%b a=%h oks=%b expected v=1 a=40 oks=1100", bus.m_valid, bus.m_addr, {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.i_valid = 1'b0; #1;
        n_checks++;
        if ({bus.m_valid, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 5'b0) begin
            n_errors++; $display("FAIL comb_idle: got %b expected 00000", {bus.m_valid, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); #1;
        n_checks++;
        if ({bus.m_valid, bus.m_write, bus.m_addr} !== {1'b1, 1'b0, 32'h80}) begin
            n_errors++; $display("FAIL comb_regrant: got v=%b w=%b a=%h expected v=1 w=0 a=80", bus.m_valid, bus.m_write, bus.m_addr);
        end
        bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b0011) begin
            n_errors++; $display("FAIL comb_d_oks: got %b expected 0011", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        bus.i_valid = 1'b1; bus.i_addr = 32'h0000_0100;
        next_cycle();
        for (int k = 0; k < 10; k++) begin
            bus.i_addr = $urandom;
            #1;
            n_checks++;
            if ({bus.m_valid, bus.m_addr, bus.i_addr_ok} !== {1'b1, 32'h100, 1'b0}) begin
                n_errors++; $display("FAIL stall[%0d]: got v=%b a=%h aok=%b expected v=1 a=100 aok=0", k, bus.m_valid, bus.m_addr, bus.i_addr_ok);
            end
            next_cycle();
        end
        bus.m_addr_ok = 1'b1; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.m_addr} !== {1'b1, 32'h100}) begin
            n_errors++; $display("FAIL stall_release: got aok=%b a=%h expected aok=1 a=100", bus.i_addr_ok, bus.m_addr);
        end
        next_cycle(); bus.m_addr_ok = 1'b0; bus.i_valid = 1'b0; bus.m_data_ok = 1'b1; #1;
        n_checks++;
        if (bus.i_data_ok !== 1'b1) begin n_errors++; $display("FAIL stall_dok: got %b expected 1", bus.i_data_ok); end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.d_valid = 1'b1; bus.d_addr = 32'h0000_0200; bus.d_strobe = 4'hF; bus.d_wdata = 32'h1234_5678;
        next_cycle(); bus.m_addr_ok = 1'b1; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b0010) begin
            n_errors++; $display("FAIL rmid_aok: got %b expected 0010", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); bus.m_addr_ok = 1'b0; bus.d_valid = 1'b0; #1;
        reset = 1'b1; bus.m_data_ok = 1'b1; #1;
        n_checks++;
        if ({bus.m_valid, bus.m_write, bus.m_addr, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== '0) begin
            n_errors++; $display("FAIL rmid_clear: got v=%b w=%b a=%h oks=%b expected all 0", bus.m_valid, bus.m_write, bus.m_addr, {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.m_data_ok = 1'b0;
        bus.d_valid = 1'b1; bus.d_addr = 32'h0000_0300; bus.d_strobe = 4'h3; bus.d_wdata = 32'hCAFE_F00D;
        #1;
        n_checks++;
        if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_idle: got %b expected 0", bus.m_valid); end
        next_cycle(); #1;
        n_checks++;
        if ({bus.m_valid, bus.m_write, bus.m_addr, bus.m_strobe, bus.m_wdata} !== {1'b1, 1'b1, 32'h300, 4'h3, 32'hCAFE_F00D}) begin
            n_errors++; $display("FAIL rmid_regrant: got v=%b w=%b a=%h st=%h wd=%h expected 1 1 300 3 cafef00d", bus.m_valid, bus.m_write, bus.m_addr, bus.m_strobe, bus.m_wdata);
        end
        bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b0011) begin
            n_errors++; $display("FAIL rmid_oks: got %b expected 0011", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); idle_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; #1;
            n_checks++;
            if ({bus.m_valid, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 5'b0) begin
                n_errors++; $display("FAIL spur[%0d]: got %b expected 00000", k, {bus.m_valid, bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
            end
            next_cycle();
        end
        bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.i_valid = 1'b1; bus.i_addr = 32'h0000_0500;
        next_cycle(); #1;
        n_checks++;
        if ({bus.m_valid, bus.m_addr} !== {1'b1, 32'h500}) begin
            n_errors++; $display("FAIL spur_grant: got v=%b a=%h expected v=1 a=500", bus.m_valid, bus.m_addr);
        end
        bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; #1;
        n_checks++;
        if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== 4'b1100) begin
            n_errors++; $display("FAIL spur_oks: got %b expected 1100", {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok});
        end
        next_cycle(); idle_inputs();
    endtask

    // Reference: a transaction is either absent, waiting for its address
    // acceptance, or waiting for completion; grants alternate under contention.
    task automatic test_random(input int cycles);
        logic            last_d, busy, owner_d, addr_done, drop_i, drop_d;
        logic            e_mvalid, a_ack, d_ack;
        logic [3:0]      e_oks;
        logic [c_aw-1:0] e_addr;
        logic [2:0]      e_size;
        logic [3:0]      e_strobe;
        logic [c_dw-1:0] e_wdata;
        do_reset();
        last_d = 1'b1; busy = 1'b0; owner_d = 1'b0; addr_done = 1'b0;
        drop_i = 1'b0; drop_d = 1'b0;
        e_addr = '0; e_size = '0; e_strobe = '0; e_wdata = '0;
        for (int c = 0; c < cycles; c++) begin
            if (drop_i) bus.i_valid = 1'b0;
            if (drop_d) bus.d_valid = 1'b0;
            drop_i = 1'b0; drop_d = 1'b0;
            if (!bus.i_valid && $urandom_range(0, 2) == 0) begin
                bus.i_valid = 1'b1; bus.i_addr = $urandom; bus.i_size = 3'($urandom_range(0, 2));
            end
            if (!bus.d_valid && $urandom_range(0, 2) == 0) begin
                bus.d_valid  = 1'b1; bus.d_addr = $urandom; bus.d_size = 3'($urandom_range(0, 2));
                bus.d_strobe = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                bus.d_wdata  = $urandom;
            end
            bus.m_addr_ok = ($urandom_range(0, 2) == 0);
            bus.m_data_ok = ($urandom_range(0, 2) == 0);
            bus.m_rdata   = $urandom;
            #1;
            e_mvalid = busy && !addr_done;
            a_ack    = e_mvalid && bus.m_addr_ok;
            d_ack    = busy && bus.m_data_ok && (addr_done || bus.m_addr_ok);
            e_oks    = {a_ack && !owner_d, d_ack && !owner_d, a_ack && owner_d, d_ack && owner_d};
            n_checks++;
            if (bus.m_valid !== e_mvalid) begin
                n_errors++; $display("FAIL rnd_mvalid[%0d]: got %b expected %b", c, bus.m_valid, e_mvalid);
            end
            n_checks++;
            if ({bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok} !== e_oks) begin
                n_errors++; $display("FAIL rnd_oks[%0d]: got %b expected %b", c, {bus.i_addr_ok, bus.i_data_ok, bus.d_addr_ok, bus.d_data_ok}, e_oks);
            end
            if (e_mvalid) begin
                n_checks++;
                if ({bus.m_addr, bus.m_size, bus.m_strobe, bus.m_write} !== {e_addr, e_size, e_strobe, |e_strobe}) begin
                    n_errors++; $display("FAIL rnd_fields[%0d]: got a=%h s=%h st=%h w=%b expected a=%h s=%h st=%h", c, bus.m_addr, bus.m_size, bus.m_strobe, bus.m_write, e_addr, e_size, e_strobe);
                end
                if (owner_d) begin
                    n_checks++;
                    if (bus.m_wdata !== e_wdata) begin n_errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", c, bus.m_wdata, e_wdata); end
                end
            end
            if (d_ack) begin
                n_checks++;
                if ((owner_d ? bus.d_data : bus.i_data) !== bus.m_rdata) begin
                    n_errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c, (owner_d ? bus.d_data : bus.i_data), bus.m_rdata);
                end
            end
            if (busy) begin
                if (a_ack) begin
                    if (owner_d) drop_d = 1'b1; else drop_i = 1'b1;
                end
                if (d_ack) busy = 1'b0;
                else if (a_ack) addr_done = 1'b1;
            end else if (bus.i_valid || bus.d_valid) begin
                owner_d   = (bus.i_valid && bus.d_valid) ? !last_d : bus.d_valid;
                last_d    = owner_d;
                busy      = 1'b1;
                addr_done = 1'b0;
                e_addr    = owner_d ? bus.d_addr : bus.i_addr;
                e_size    = owner_d ? bus.d_size : bus.i_size;
                e_strobe  = owner_d ? bus.d_strobe : 4'h0;
                e_wdata   = bus.d_wdata;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_alternation();
        test_combined_ok();
        test_stall();
        test_reset_mid();
        test_spurious();
        test_random(1500);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
